// File: rtl/adc_delay_sequencer.sv
// Serialises per-channel IDELAY tap updates onto one shared tap bus: pick the lowest
// pending channel, load it, wait for it to settle, then record the applied value.
// Build option: define ADC_DLY_READBACK_EN to capture the IDELAY readback instead of the written value.
module adc_delay_sequencer #(
  parameter int NUM_CH        = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH*9-1:0]   delay_in,
  input  logic [NUM_CH-1:0]     delay_in_strobe,
  input  logic                  load_all,
  output logic [8:0]            dly_cntvaluein,
  output logic [NUM_CH-1:0]     dly_load,
`ifdef ADC_DLY_READBACK_EN
  input  logic [NUM_CH*9-1:0]   dly_cntvalueout,
`endif
  output logic [NUM_CH*9-1:0]   delay_out,
  output logic                  busy,
  output logic                  train_done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    SETTLE,
    CAPTURE
  } state_e;

  state_e                state_q;
  logic [CH_W-1:0]       sel_q;
  logic [NUM_CH-1:0]     pending_q;
  logic [NUM_CH-1:0]     pending_d;
  logic [NUM_CH-1:0]     done_q;
  logic [NUM_CH-1:0]     done_d;
  logic [7:0]            settle_q;
  logic [8:0]            cntvalue_q;
  logic [NUM_CH-1:0]     load_q;
  logic [NUM_CH*9-1:0]   delay_out_q;
  logic [8:0]            capture_val;
  int unsigned           sel_idx;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] vec);
    lowest_set = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (vec[c]) lowest_set = CH_W'(c);
    end
  endfunction

  assign sel_idx = 32'(sel_q);

`ifdef ADC_DLY_READBACK_EN
  assign capture_val = dly_cntvalueout[sel_idx*9 +: 9];
`else
  assign capture_val = cntvalue_q;
`endif

  // The SETUP clear is applied before the strobe OR so a same-cycle strobe re-arms the channel.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
    pending_d = pending_q;
    if (state_q == SETUP) pending_d[sel_q] = 1'b0;
    pending_d = pending_d | delay_in_strobe;
    if (load_all) pending_d = '1;

    done_d = done_q;
    if (state_q == CAPTURE) done_d[sel_q] = 1'b1;
    if (load_all) done_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking '<='; the small delay_out array is reset
      // because downstream logic reads it as "applied tap" straight after reset.
      state_q     <= IDLE;
      sel_q       <= '0;
      pending_q   <= '0;
      done_q      <= '0;
      settle_q    <= '0;
      cntvalue_q  <= '0;
      load_q      <= '0;
      delay_out_q <= '0;
    end else begin
      pending_q <= pending_d;
      done_q    <= done_d;
      load_q    <= '0;
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            sel_q   <= lowest_set(pending_q);
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cntvalue_q <= delay_in[sel_idx*9 +: 9];
          load_q     <= NUM_CH'(1) << sel_q;
          state_q    <= LOAD;
        end
        LOAD: begin
          settle_q <= 8'(SETTLE_CYCLES - 1);
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == 8'd0) state_q <= CAPTURE;
          else                  settle_q <= settle_q - 8'd1;
        end
        CAPTURE: begin
          delay_out_q[sel_idx*9 +: 9] <= capture_val;
          // Chain straight into the next channel so back-to-back requests never idle.
          if (|pending_q) begin
            sel_q   <= lowest_set(pending_q);
            state_q <= SETUP;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dly_cntvaluein = cntvalue_q;
  assign dly_load       = load_q;
  assign delay_out      = delay_out_q;
  assign busy           = (state_q != IDLE) || (|pending_q);
  assign train_done     = (&done_q) && (state_q == IDLE) && !(|pending_q);

endmodule

// File: tb/tb_adc_delay_sequencer.sv
// Self-checking bench for adc_delay_sequencer: directed vector table, multi-cycle corner
// sequences, and random strobe bursts against a request-queue timing model.
module tb_adc_delay_sequencer;

  localparam int NUM_CH = 16;
  localparam int S      = 4;
  localparam int W      = NUM_CH * 9;
  localparam int SLOT   = S + 3;
`ifdef ADC_DLY_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      delay_in;
  logic [NUM_CH-1:0] delay_in_strobe;
  logic              load_all;
  logic [8:0]        dly_cntvaluein;
  logic [NUM_CH-1:0] dly_load;
  logic [W-1:0]      delay_out;
  logic              busy;
  logic              train_done;
  logic [8:0]        rb [NUM_CH];
`ifdef ADC_DLY_READBACK_EN
  logic [W-1:0]      dly_cntvalueout;
  always_comb begin
    dly_cntvalueout = '0;
    for (int c = 0; c < NUM_CH; c++) dly_cntvalueout[c*9 +: 9] = rb[c];
  end
`endif

  always #5 clk = ~clk;

  adc_delay_sequencer #(.NUM_CH(NUM_CH), .SETTLE_CYCLES(S)) dut (
    .clk             (clk),
    .rst             (rst),
    .delay_in        (delay_in),
    .delay_in_strobe (delay_in_strobe),
    .load_all        (load_all),
    .dly_cntvaluein  (dly_cntvaluein),
    .dly_load        (dly_load),
`ifdef ADC_DLY_READBACK_EN
    .dly_cntvalueout (dly_cntvalueout),
`endif
    .delay_out       (delay_out),
    .busy            (busy),
    .train_done      (train_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference state: what each channel should currently report, and which have completed.
  logic [8:0]        model_out [NUM_CH];
  logic [NUM_CH-1:0] done_model;

  function automatic logic [8:0] exp_cap(input logic [8:0] written, input logic [8:0] readback);
    return RB_EN ? readback : written;
  endfunction

  function automatic logic [8:0] slice(input logic [W-1:0] v, input int c);
    return v[c*9 +: 9];
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c*9 +: 9] = model_out[c];
    return v;
  endfunction

  // Per-cycle observation history, index k = state after clock edge k (edge 0 samples the request).
  logic [NUM_CH-1:0] load_hist [256];
  logic [8:0]        cv_hist   [256];
  logic [W-1:0]      out_hist  [256];
  logic              busy_hist [256];
  int                ld_k [$];
  int                busy_fall_k;
  int                td_rise_k;
  bit                multi_hot;

  function automatic int ld_at(input int i);
    return (i < ld_k.size()) ? ld_k[i] : -1;
  endfunction

  task automatic fire(input logic [NUM_CH-1:0] strb, input logic la);
    @(negedge clk);
    delay_in_strobe = strb;
    load_all        = la;
    @(posedge clk);
    @(negedge clk);
    delay_in_strobe = '0;
    load_all        = 1'b0;
  endtask

  task automatic run_cycles(input int n, input int inj_k, input int inj_ch, input logic [8:0] inj_val);
    ld_k.delete();
    busy_fall_k = -1;
    td_rise_k   = -1;
    multi_hot   = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      load_hist[k] = dly_load;
      cv_hist[k]   = dly_cntvaluein;
      out_hist[k]  = delay_out;
      busy_hist[k] = busy;
      if (dly_load != '0) ld_k.push_back(k);
      if ($countones(dly_load) > 1) multi_hot = 1'b1;
      if (!busy && busy_fall_k < 0) busy_fall_k = k;
      if (train_done && td_rise_k < 0) td_rise_k = k;
      delay_in_strobe = '0;
      if (k == inj_k) begin
        delay_in[inj_ch*9 +: 9]  = inj_val;
        delay_in_strobe[inj_ch] = 1'b1;
      end
    end
  endtask

  typedef struct {
    int                ch;
    logic [8:0]        val;
    logic [NUM_CH-1:0] exp_load;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]        prev;
    logic [W-1:0]      exp_vec;
    logic [NUM_CH-1:0] strb;
    int                errs;
    int                n;
    int                idx;
    bit                gapless;

    tbl[0] = '{ch: 3,  val: 9'h0A5, exp_load: 16'h0008};
    tbl[1] = '{ch: 0,  val: 9'h100, exp_load: 16'h0001};
    tbl[2] = '{ch: 15, val: 9'h1FF, exp_load: 16'h8000};
    tbl[3] = '{ch: 4,  val: 9'h040, exp_load: 16'h0010};
    tbl[4] = '{ch: 9,  val: 9'h07E, exp_load: 16'h0200};

    for (int c = 0; c < NUM_CH; c++) begin
      rb[c]        = 9'($urandom);
      model_out[c] = '0;
    end
    rb[4]      = 9'h033;
    done_model = '0;

    // Reset state
    rst             = 1'b1;
    delay_in        = '0;
    delay_in_strobe = '0;
    load_all        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dly_load", dly_load, '0);
    check("rst_cntvaluein", dly_cntvaluein, '0);
    check("rst_delay_out", delay_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_train_done", train_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_train_done", train_done, 1'b0);

    // Single-channel vector table
    for (int i = 0; i < 5; i++) begin
      prev = model_out[tbl[i].ch];
      delay_in[tbl[i].ch*9 +: 9] = tbl[i].val;
      fire(NUM_CH'(1) << tbl[i].ch, 1'b0);
      run_cycles(S + 6, 0, 0, 9'h0);
      check($sformatf("v%0d_load_count", i), ld_k.size(), 1);
      check($sformatf("v%0d_load_edge", i), ld_at(0), 2);
      check($sformatf("v%0d_dly_load", i), load_hist[2], tbl[i].exp_load);
      check($sformatf("v%0d_load_cleared", i), load_hist[3], '0);
      check($sformatf("v%0d_cntvaluein", i), cv_hist[2], tbl[i].val);
      check($sformatf("v%0d_out_before", i), slice(out_hist[S+3], tbl[i].ch), prev);
      check($sformatf("v%0d_out_after", i), slice(out_hist[S+4], tbl[i].ch),
            exp_cap(tbl[i].val, rb[tbl[i].ch]));
      check($sformatf("v%0d_busy_fall", i), busy_fall_k, S + 4);
      model_out[tbl[i].ch] = exp_cap(tbl[i].val, rb[tbl[i].ch]);
      done_model[tbl[i].ch] = 1'b1;
    end

    // Two strobes in one cycle: lower index first, no idle gap
    delay_in[2*9 +: 9] = 9'h011;
    delay_in[7*9 +: 9] = 9'h177;
    fire(16'h0084, 1'b0);
    run_cycles(2*SLOT + 3, 0, 0, 9'h0);
    check("pair_load_count", ld_k.size(), 2);
    check("pair_first_edge", ld_at(0), 2);
    check("pair_first_load", load_hist[2], 16'h0004);
    check("pair_second_edge", ld_at(1), 2 + SLOT);
    check("pair_second_load", load_hist[2+SLOT], 16'h0080);
    check("pair_second_value", cv_hist[2+SLOT], 9'h177);
    gapless = 1'b1;
    for (int k = 1; k <= 2*SLOT; k++) if (!busy_hist[k]) gapless = 1'b0;
    check("pair_no_idle_gap", gapless, 1'b1);
    check("pair_busy_fall", busy_fall_k, 1 + 2*SLOT);
    check("pair_out_ch2", slice(out_hist[S+4], 2), exp_cap(9'h011, rb[2]));
    check("pair_out_ch7", slice(out_hist[1+2*SLOT], 7), exp_cap(9'h177, rb[7]));
    model_out[2] = exp_cap(9'h011, rb[2]);
    model_out[7] = exp_cap(9'h177, rb[7]);
    done_model[2] = 1'b1;
    done_model[7] = 1'b1;

    // Re-strobe of the in-flight channel during its settle window
    delay_in[5*9 +: 9] = 9'h0AA;
    fire(16'h0020, 1'b0);
    run_cycles(2*SLOT + 3, 4, 5, 9'h1FF);
    check("rest_first_value", cv_hist[2], 9'h0AA);
    check("rest_load_count", ld_k.size(), 2);
    check("rest_reload_edge", ld_at(1), 2 + SLOT);
    check("rest_reload_load", load_hist[2+SLOT], 16'h0020);
    check("rest_reload_value", cv_hist[2+SLOT], 9'h1FF);
    check("rest_first_out", slice(out_hist[S+4], 5), exp_cap(9'h0AA, rb[5]));
    check("rest_final_out", slice(out_hist[1+2*SLOT], 5), exp_cap(9'h1FF, rb[5]));
    check("rest_busy_fall", busy_fall_k, 1 + 2*SLOT);
    model_out[5] = exp_cap(9'h1FF, rb[5]);
    done_model[5] = 1'b1;

    // delay_in changes without a strobe do nothing
    for (int c = 0; c < NUM_CH; c++) delay_in[c*9 +: 9] = 9'($urandom);
    run_cycles(5, 0, 0, 9'h0);
    check("nostrobe_loads", ld_k.size(), 0);
    check("nostrobe_delay_out", delay_out, model_vec());
    check("nostrobe_busy", busy_fall_k, 1);
    check("nostrobe_train_done", td_rise_k, -1);

    // load_all: every channel in index order, train_done with busy falling
    exp_vec = '0;
    for (int c = 0; c < NUM_CH; c++) exp_vec[c*9 +: 9] = exp_cap(slice(delay_in, c), rb[c]);
    fire('0, 1'b1);
    run_cycles(NUM_CH*SLOT + 4, 0, 0, 9'h0);
    check("lall_load_count", ld_k.size(), NUM_CH);
    errs = 0;
    for (int i = 0; i < ld_k.size(); i++) begin
      if (ld_k[i] != 2 + i*SLOT) errs++;
      if (load_hist[ld_k[i]] !== NUM_CH'(1) << i) errs++;
      if (cv_hist[ld_k[i]] !== slice(delay_in, i)) errs++;
    end
    check("lall_order_errors", errs, 0);
    check("lall_multi_hot", multi_hot, 1'b0);
    check("lall_train_done_rise", td_rise_k, 1 + NUM_CH*SLOT);
    check("lall_busy_fall", busy_fall_k, 1 + NUM_CH*SLOT);
    check("lall_delay_out", delay_out, exp_vec);
    for (int c = 0; c < NUM_CH; c++) model_out[c] = slice(exp_vec, c);

    // Reset during LOAD of channel 9, with a strobe presented while reset is held
    delay_in[9*9 +: 9] = 9'h123;
    fire(16'h0200, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_load", dly_load, 16'h0200);
    #1 rst = 1'b1;
    #1;
    check("abort_dly_load_async", dly_load, '0);
    check("abort_delay_out", delay_out, '0);
    check("abort_cntvaluein", dly_cntvaluein, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_train_done", train_done, 1'b0);
    delay_in_strobe = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    delay_in_strobe = '0;
    rst = 1'b0;
    run_cycles(20, 0, 0, 9'h0);
    check("abort_no_reload", ld_k.size(), 0);
    check("abort_idle", busy_fall_k, 1);
    check("abort_out_zero", delay_out, '0);
    for (int c = 0; c < NUM_CH; c++) model_out[c] = '0;
    done_model = '0;

    // Random bursts: requests served lowest index first, SLOT cycles each
    for (int r = 0; r < 20; r++) begin
      strb = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      for (int c = 0; c < NUM_CH; c++) delay_in[c*9 +: 9] = 9'($urandom);
      n = $countones(strb);
      fire(strb, 1'b0);
      run_cycles(1 + n*SLOT + 3, 0, 0, 9'h0);
      errs = 0;
      idx  = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (strb[c]) begin
          if (ld_at(idx) != 2 + idx*SLOT) errs++;
          else begin
            if (load_hist[ld_k[idx]] !== NUM_CH'(1) << c) errs++;
            if (cv_hist[ld_k[idx]] !== slice(delay_in, c)) errs++;
          end
          model_out[c] = exp_cap(slice(delay_in, c), rb[c]);
          idx++;
        end
      end
      done_model = done_model | strb;
      check($sformatf("rnd%0d_load_count", r), ld_k.size(), n);
      check($sformatf("rnd%0d_sequence_errors", r), errs, 0);
      check($sformatf("rnd%0d_multi_hot", r), multi_hot, 1'b0);
      check($sformatf("rnd%0d_busy_fall", r), busy_fall_k, 1 + n*SLOT);
      check($sformatf("rnd%0d_train_done", r), td_rise_k, (&done_model) ? 1 + n*SLOT : -1);
      check($sformatf("rnd%0d_delay_out", r), delay_out, model_vec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_delay_sequencer.md
ADC_DELAY_SEQUENCER -- requirements
Module: adc_delay_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 16: number of ADC channels and IDELAY elements.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, legal range 1..255: number of wait cycles between the load pulse and the readback capture.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port delay_in, input, NUM_CH*9 bits: per-channel target tap value; channel c occupies bits [9c+8:9c].
REQ-006 SHALL have port delay_in_strobe, input, NUM_CH bits: one-cycle write strobe per channel.
REQ-007 SHALL have port load_all, input, 1 bit: one-cycle request to reload every channel.
REQ-008 SHALL have port dly_cntvaluein, output, 9 bits: shared tap value bus to the IDELAYs.
REQ-009 SHALL have port dly_load, output, NUM_CH bits: one-hot load pulse.
REQ-010 SHALL have port dly_cntvalueout, input, NUM_CH*9 bits: per-channel tap readback (present only under the macro in REQ-030).
REQ-011 SHALL have port delay_out, output, NUM_CH*9 bits: per-channel applied tap value.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state machine is not in IDLE or any channel is pending.
REQ-013 SHALL have port train_done, output, 1 bit: all channels loaded and the block idle.

Function
REQ-014 SHALL keep a NUM_CH-bit pending vector: at each edge, bit c is set when delay_in_strobe[c]=1, and all bits are set when load_all=1.
REQ-015 SHALL sequence through the states IDLE -> SETUP -> LOAD -> SETTLE -> CAPTURE; every state lasts one cycle except SETTLE, which lasts SETTLE_CYCLES cycles.
REQ-016 SHALL, in IDLE with pending nonzero, select the lowest-index pending channel and move to SETUP.
REQ-017 SHALL, in SETUP, register dly_cntvaluein from the selected channel's delay_in slice and clear that channel's pending bit.
REQ-018 SHALL hold dly_cntvaluein stable from SETUP through CAPTURE.
REQ-019 SHALL drive dly_load[ch]=1 only during LOAD, and all other dly_load bits 0; at most one dly_load bit is ever high.
REQ-020 SHALL, in CAPTURE, write the captured value into delay_out[ch], then move to SETUP if pending is nonzero, else to IDLE.
REQ-021 SHALL meet this latency: a strobe sampled at edge 0 with the block idle gives dly_load high between edges 2 and 3, and delay_out updated at edge 4+SETTLE_CYCLES.
REQ-022 SHALL, when a strobe arrives for the channel currently in flight, set its pending bit again; the in-flight load keeps the value latched in SETUP, and the channel is reloaded afterwards.
REQ-023 SHALL treat a strobe and a clear of the same pending bit in the same cycle as a set (the set wins).
REQ-024 SHALL keep a NUM_CH-bit done vector: bit ch is set in CAPTURE, and all bits are cleared by load_all.
REQ-025 SHALL drive train_done = (all done bits set) AND (state is IDLE) AND (pending is zero).
REQ-026 SHALL leave changes on delay_in without a strobe without effect.

Reset
REQ-027 SHALL, while rst=1, force: state IDLE; pending = 0; done = 0; dly_cntvaluein = 0; dly_load = 0; delay_out = 0; busy = 0; train_done = 0.
REQ-028 SHALL, when rst is asserted mid-sequence, abort the sequence immediately and drop dly_load asynchronously; the aborted channel is not reloaded after reset.
REQ-029 SHALL ignore strobes sampled while rst=1.

Configuration
REQ-030 SHALL support the macro ADC_DLY_READBACK_EN:
- Defined: the dly_cntvalueout port exists; CAPTURE stores dly_cntvalueout[ch] into delay_out[ch].
- Undefined: the port is absent; CAPTURE stores the latched dly_cntvaluein into delay_out[ch].
- Timing and state sequence are identical in both builds.

Verification
REQ-031 SHALL cover: reset, then strobe[3] with delay_in[3]=9'h0A5 -> dly_cntvaluein=0A5, dly_load=16'h0008 for exactly one cycle at edge 2, delay_out[3] updated at edge 8 (SETTLE_CYCLES=4).
REQ-032 SHALL cover: strobes [7] and [2] in the same cycle -> channel 2 loads first, then channel 7 with no IDLE cycle between them; a 14-cycle sequence.
REQ-033 SHALL cover: load_all -> 16 loads in index order 0..15; train_done rises one cycle after the 16th CAPTURE; busy falls in the same cycle.
REQ-034 SHALL cover: strobe[5] again during channel 5's SETTLE with a new value 9'h1FF -> the first load completes with the old value, then channel 5 is reloaded with 1FF.
REQ-035 SHALL cover: rst pulsed during LOAD of channel 9 -> dly_load=0 at once, all outputs 0, no further loads until a new strobe.
REQ-036 SHALL cover: build with ADC_DLY_READBACK_EN defined and dly_cntvalueout[4] forced to 9'h033 while 9'h040 is written -> delay_out[4]=033; without the macro, delay_out[4]=040.
